// File: rtl/efpga_accel_bridge.sv
// efpga_accel_bridge
// Memory-mapped slave on the core data bus that hands N operands to the eFPGA
// fabric and runs a start/done handshake with it. A programmable watchdog can
// abort a run. Up to M results are captured, along with the run latency, and
// a level interrupt is raised on completion or timeout.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   data_req_i .. data_err_o  zero-wait bus slave; response one cycle after grant
//   efpga_operand_o         operand registers, operand i at [32i+31:32i]
//   efpga_start_o           one-cycle start pulse to the fabric
//   efpga_done_i            fabric completion, only looked at while running
//   efpga_result_i          fabric results, result j at [32j+31:32j]
//   irq_o                   IRQ_EN & (DONE | TIMEOUT)
//
// Register map (byte offsets)
//   0x000 CTRL    W   bit0 START, bit1 IRQ_EN (reads back), bit2 CLR
//   0x004 STATUS  RO  bit0 BUSY, bit1 DONE, bit2 TIMEOUT
//   0x008 TIMEOUT RW  watchdog limit, 0 = disabled
//   0x00C CYCLES  RO  latency of the last finished run
//   0x040+4i OPERAND[i] RW, 0x080+4j RESULT[j] RO
//
// state | meaning
// IDLE  | waiting for a START write; operand/limit writes accepted
// RUN   | start issued, counting cycles until done or watchdog expiry

module efpga_accel_bridge #(
    parameter int NUM_OPS   = 2,
    parameter int NUM_RES   = 3,
    parameter int TIMEOUT_W = 16,
    parameter int ADDR_W    = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [3:0]             data_be_i,
    input  logic [ADDR_W-1:0]      data_addr_i,
    input  logic [31:0]            data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [31:0]            data_rdata_o,
    output logic                   data_err_o,
    output logic [NUM_OPS*32-1:0]  efpga_operand_o,
    output logic                   efpga_start_o,
    input  logic                   efpga_done_i,
    input  logic [NUM_RES*32-1:0]  efpga_result_i,
    output logic                   irq_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]           state;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [TIMEOUT_W-1:0] limit;
    logic [TIMEOUT_W-1:0] cycles;
    logic [31:0]          operand [NUM_OPS];
    logic [31:0]          result  [NUM_RES];
    logic                 irq_en;
    logic                 done_flag;
    logic                 to_flag;
    logic                 start_pulse;
    logic                 busy;

    logic [ADDR_W-3:0]    word;
    logic [ADDR_W-7:0]    region;
    logic [3:0]           idx;
    logic                 sel_ctrl, sel_status, sel_limit, sel_cycles;
    logic                 in_ops, in_res;
    logic                 mapped;
    logic [31:0]          rd_val;
    logic [NUM_OPS-1:0]   op_sel;
    logic [31:0]          be_mask;
    logic [31:0]          limit_word;
    logic [31:0]          limit_new;
    logic                 wr;
    logic                 wr_idle;
    logic                 start_req;
    logic                 clr_req;
    logic                 unused_bits;

    assign busy        = (state == S_RUN);
    assign word        = data_addr_i[ADDR_W-1:2];
    assign region      = data_addr_i[ADDR_W-1:6];
    assign idx         = data_addr_i[5:2];
    assign sel_ctrl    = (word == (ADDR_W-2)'(0));
    assign sel_status  = (word == (ADDR_W-2)'(1));
    assign sel_limit   = (word == (ADDR_W-2)'(2));
    assign sel_cycles  = (word == (ADDR_W-2)'(3));
    assign in_ops      = (region == (ADDR_W-6)'(1));
    assign in_res      = (region == (ADDR_W-6)'(2));

    assign wr          = data_req_i & data_we_i;
    assign wr_idle     = wr & ~busy;
    assign start_req   = wr & sel_ctrl & data_wdata_i[0];
    assign clr_req     = wr & sel_ctrl & data_wdata_i[2];

    assign be_mask     = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                          {8{data_be_i[1]}}, {8{data_be_i[0]}}};

    // Counter saturates rather than wrapping so CYCLES never reads back small
    // after a very long unwatched run.
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + TIMEOUT_W'(1);

    always_comb begin
        limit_word = '0;
        limit_word[TIMEOUT_W-1:0] = limit;
        limit_new  = (limit_word & ~be_mask) | (data_wdata_i & be_mask);
    end

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        op_sel = '0;
        if (sel_ctrl) begin
            mapped    = 1'b1;
            rd_val[1] = irq_en;
        end
        if (sel_status) begin
            mapped      = 1'b1;
            rd_val[2:0] = {to_flag, done_flag, busy};
        end
        if (sel_limit) begin
            mapped = 1'b1;
            rd_val[TIMEOUT_W-1:0] = limit;
        end
        if (sel_cycles) begin
            mapped = 1'b1;
            rd_val[TIMEOUT_W-1:0] = cycles;
        end
        for (int i = 0; i < NUM_OPS; i++) begin
            if (in_ops && idx == 4'(i)) begin
                mapped    = 1'b1;
                rd_val    = operand[i];
                op_sel[i] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RES; j++) begin
            if (in_res && idx == 4'(j)) begin
                mapped = 1'b1;
                rd_val = result[j];
            end
        end
    end

    // Bus response: every granted request answers exactly one cycle later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= data_req_i;
            data_rdata_o  <= (data_req_i && !data_we_i) ? rd_val : '0;
            data_err_o    <= data_req_i & ~mapped;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            cnt         <= '0;
            limit       <= '0;
            cycles      <= '0;
            irq_en      <= 1'b0;
            done_flag   <= 1'b0;
            to_flag     <= 1'b0;
            start_pulse <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) operand[i] <= '0;
            for (int j = 0; j < NUM_RES; j++) result[j]  <= '0;
        end else begin
            start_pulse <= 1'b0;
            if (wr && sel_ctrl) irq_en <= data_wdata_i[1];
            // Clear first so a flag raised in this same cycle below survives.
            if (clr_req) begin
                done_flag <= 1'b0;
                to_flag   <= 1'b0;
            end
            if (wr_idle && sel_limit) limit <= limit_new[TIMEOUT_W-1:0];
            for (int i = 0; i < NUM_OPS; i++) begin
                if (wr_idle && op_sel[i])
                    operand[i] <= (operand[i] & ~be_mask) | (data_wdata_i & be_mask);
            end
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        start_pulse <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt_inc;
                    if (efpga_done_i) begin
                        for (int j = 0; j < NUM_RES; j++)
                            result[j] <= efpga_result_i[32*j +: 32];
                        done_flag <= 1'b1;
                        cycles    <= cnt_inc;
                        state     <= S_IDLE;
                    end else if (limit != '0 && cnt_inc == limit) begin
                        to_flag <= 1'b1;
                        cycles  <= limit;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        assign efpga_operand_o[32*g +: 32] = operand[g];
    end

    assign data_gnt_o    = data_req_i;
    assign efpga_start_o = start_pulse;
    assign irq_o         = irq_en & (done_flag | to_flag);

    assign unused_bits   = ^{data_addr_i[1:0], limit_new};

endmodule

// File: tb/tb_efpga_accel_bridge.sv
// Directed bench for efpga_accel_bridge with a small fabric model that raises
// done in a chosen RUN cycle (RUN cycle 1 is the cycle efpga_start_o is high).

module tb_efpga_accel_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [63:0] op_o;
    logic        start;
    logic        done;
    logic [95:0] res;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    int   done_at   = 0;
    int   rc        = 0;
    int   start_cnt = 0;
    logic fab_done   = 1'b0;
    logic force_done = 1'b0;

    logic [11:0] map_addrs [9] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                   12'h040, 12'h044, 12'h080, 12'h084, 12'h088};

    assign done = fab_done | force_done;
    assign res  = {32'd3, 32'd2, 32'd1};

    efpga_accel_bridge dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .data_req_i      (req),
        .data_we_i       (we),
        .data_be_i       (be),
        .data_addr_i     (addr),
        .data_wdata_i    (wdata),
        .data_gnt_o      (gnt),
        .data_rvalid_o   (rvalid),
        .data_rdata_o    (rdata),
        .data_err_o      (err),
        .efpga_operand_o (op_o),
        .efpga_start_o   (start),
        .efpga_done_i    (done),
        .efpga_result_i  (res),
        .irq_o           (irq)
    );

    always @(posedge clk) begin
        #1;
        if (start === 1'b1) begin
            rc = 1;
            start_cnt++;
        end else if (rc != 0) begin
            rc++;
        end
        fab_done = (done_at != 0 && rc == done_at);
        if (fab_done) rc = 0;
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(posedge clk); #1;
        d = rdata; e = err;
        req = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        e;
        rst_n = 1'b0;
        wait_cycles(2);
        n_checks++;
        if ({start, irq, rvalid, err, rdata, op_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", {start, irq, rvalid, err, rdata, op_o});
        end
        rst_n = 1'b1;
        wait_cycles(1);
        for (int k = 0; k < 9; k++) begin
            bus_read(map_addrs[k], d, e);
            n_checks++;
            if (d !== 32'h0 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_reg_%h: got data %h err %b, expected 0 err 0", map_addrs[k], d, e);
            end
        end
        bus_read(12'h100, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_read: got data %h err %b, expected 0 err 1", d, e);
        end
        bus_read(12'h048, d, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL operand_oob_err: got %b, expected 1", e); end
        bus_read(12'h08C, d, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL result_oob_err: got %b, expected 1", e); end
    endtask

    task automatic test_operands;
        logic [31:0] d;
        logic        e;
        req = 1'b1; we = 1'b0; addr = 12'h040;
        #1;
        n_checks++;
        if (gnt !== 1'b1) begin n_fail++; $display("FAIL grant_comb: got %b, expected 1", gnt); end
        @(posedge clk); #1;
        req = 1'b0;
        bus_write(12'h040, 32'h12345678, 4'hF);
        bus_write(12'h044, 32'hA5A5A5A5, 4'h3);
        n_checks++;
        if (rvalid !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp: got rvalid %b err %b, expected 1 0", rvalid, err);
        end
        n_checks++;
        if (op_o !== 64'h0000A5A5_12345678) begin
            n_fail++;
            $display("FAIL operand_out: got %h, expected 0000a5a512345678", op_o);
        end
        bus_read(12'h044, d, e);
        n_checks++;
        if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL operand1_read: got %h, expected 0000a5a5", d); end
        wait_cycles(1);
        n_checks++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_idle: got %b, expected 0", rvalid); end
        bus_write(12'h004, 32'h7, 4'hF);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL ro_write_err: got %b, expected 0", err); end
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ro_write_ignored: got %h, expected 0", d); end
        bus_write(12'h100, 32'h1, 4'hF);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL unmapped_write_err: got %b, expected 1", err); end
    endtask

    task automatic test_done;
        logic [31:0] d;
        logic        e;
        done_at = 5;
        start_cnt = 0;
        bus_write(12'h000, 32'h1, 4'hF);
        n_checks++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL start_pulse_t1: got %b, expected 1", start); end
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL status_busy: got %h, expected 1", d); end
        n_checks++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL start_pulse_t2: got %b, expected 0", start); end
        wait_cycles(4);
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL status_done: got %h, expected 2", d); end
        n_checks++;
        if (start_cnt !== 1) begin n_fail++; $display("FAIL start_count_done: got %0d, expected 1", start_cnt); end
        bus_read(12'h00C, d, e);
        n_checks++;
        if (d !== 32'd5) begin n_fail++; $display("FAIL cycles_done: got %0d, expected 5", d); end
        for (int j = 0; j < 3; j++) begin
            bus_read(12'h080 + 12'(4 * j), d, e);
            n_checks++;
            if (d !== 32'(j + 1)) begin
                n_fail++;
                $display("FAIL result%0d: got %h, expected %h", j, d, 32'(j + 1));
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b, expected 0", irq); end
        done_at = 0;
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        logic        e;
        done_at = 0;
        bus_write(12'h008, 32'd10, 4'hF);
        start_cnt = 0;
        bus_write(12'h000, 32'h7, 4'hF);
        wait_cycles(9);
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL status_run_cycle10: got %h, expected 1", d); end
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL status_timeout: got %h, expected 4", d); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_timeout: got %b, expected 1", irq); end
        bus_read(12'h00C, d, e);
        n_checks++;
        if (d !== 32'd10) begin n_fail++; $display("FAIL cycles_timeout: got %0d, expected 10", d); end
        bus_read(12'h080, d, e);
        n_checks++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL result_kept: got %h, expected 1", d); end
        bus_read(12'h000, d, e);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL ctrl_irq_en_read: got %h, expected 2", d); end
        n_checks++;
        if (start_cnt !== 1) begin n_fail++; $display("FAIL start_count_timeout: got %0d, expected 1", start_cnt); end
        bus_write(12'h000, 32'h4, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b, expected 0", irq); end
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL status_cleared: got %h, expected 0", d); end
    endtask

    task automatic test_done_beats_timeout;
        logic [31:0] d;
        logic        e;
        bus_write(12'h008, 32'd4, 4'hF);
        done_at = 4;
        bus_write(12'h000, 32'h1, 4'hF);
        wait_cycles(4);
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL done_vs_timeout_status: got %h, expected 2", d); end
        bus_read(12'h00C, d, e);
        n_checks++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL done_vs_timeout_cycles: got %0d, expected 4", d); end
        done_at = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic        e;
        done_at = 0;
        bus_write(12'h008, 32'd50, 4'hF);
        start_cnt = 0;
        bus_write(12'h000, 32'h5, 4'hF);
        bus_write(12'h000, 32'h1, 4'hF);
        bus_write(12'h040, 32'hFFFFFFFF, 4'hF);
        bus_write(12'h008, 32'd1, 4'hF);
        n_checks++;
        if (op_o[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL operand_busy_write: got %h, expected 12345678", op_o[31:0]);
        end
        bus_read(12'h008, d, e);
        n_checks++;
        if (d !== 32'd50) begin n_fail++; $display("FAIL limit_busy_write: got %0d, expected 50", d); end
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL status_still_busy: got %h, expected 1", d); end
        n_checks++;
        if (start_cnt !== 1) begin n_fail++; $display("FAIL start_while_busy: got %0d, expected 1", start_cnt); end
        rst_n = 1'b0;
        force_done = 1'b1;
        wait_cycles(1);
        n_checks++;
        if ({start, irq, rvalid, err, rdata, op_o} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got %h, expected 0", {start, irq, rvalid, err, rdata, op_o});
        end
        rst_n = 1'b1;
        wait_cycles(1);
        force_done = 1'b0;
        bus_read(12'h004, d, e);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL status_after_reset: got %h, expected 0", d); end
        bus_read(12'h00C, d, e);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cycles_after_reset: got %h, expected 0", d); end
        n_checks++;
        if (start_cnt !== 1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL no_start_after_reset: got count %0d start %b, expected 1 0", start_cnt, start);
        end
    endtask

    initial begin
        req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; rst_n = 1'b0;
        test_reset;
        test_operands;
        test_done;
        test_timeout;
        test_done_beats_timeout;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
